// File: rtl/mul8_seq_ctrl_pkg.sv
// Shared types and widths for the sequential 8x8 multiplier controller.
package mul_seq_pkg;

  localparam int OP_W   = 8;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;
  localparam int STEP_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Two's-complement magnitude; -128 maps to 0x80, read as unsigned 128.
  function automatic logic [OP_W-1:0] abs_op(input logic [OP_W-1:0] v);
    return v[OP_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Operand/result handshake bundle; master = producer/consumer side, slave = controller.
interface mul8_seq_ctrl_if;
  import mul_seq_pkg::*;

  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] out_product;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_a, in_b, in_valid, out_ready,
    input  in_ready, out_product, out_valid
  );

  modport slave (
    input  in_a, in_b, in_valid, out_ready,
    output in_ready, out_product, out_valid
  );

endinterface

// File: rtl/mul8_seq_ctrl_pp_mul4.sv
// Purely combinational 4x4 unsigned array multiplier (shift-and-add rows).
module pp_mul4
  import mul_seq_pkg::*;
(
  input  logic [NIB_W-1:0]   a_i,
  input  logic [NIB_W-1:0]   b_i,
  output logic [2*NIB_W-1:0] p_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    p_o = '0;
    for (int i = 0; i < NIB_W; i++) begin
      if (b_i[i]) p_o = p_o + ({{NIB_W{1'b0}}, a_i} << i);
    end
  end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 multiplier sequencing one 4x4 array through four nibble partial products.
// Define MUL_SEQ_SIGNED_EN for two's-complement operands and result.
module mul8_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  mul8_seq_ctrl_if.slave  bus,
  output logic            busy
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
`ifdef MUL_SEQ_SIGNED_EN
  logic                sign_q, sign_d;
`endif

  logic [NIB_W-1:0]    nib_a, nib_b;
  logic [2*NIB_W-1:0]  pp;
  logic [1:0]          nib_pos;
  logic [PROD_W-1:0]   pp_shifted, acc_sum;
  logic                zero_op;

  // step[0] selects the high nibble of a, step[1] the high nibble of b.
  assign nib_a      = step_q[0] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
  assign nib_b      = step_q[1] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];
  assign nib_pos    = {1'b0, step_q[0]} + {1'b0, step_q[1]};
  assign pp_shifted = PROD_W'(pp) << {nib_pos, 2'b00};
  assign acc_sum    = acc_q + pp_shifted;
  assign zero_op    = (a_q == '0) || (b_q == '0);

  pp_mul4 u_pp_mul4 (
    .a_i (nib_a),
    .b_i (nib_b),
    .p_o (pp)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef MUL_SEQ_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
`ifdef MUL_SEQ_SIGNED_EN
          a_d    = abs_op(bus.in_a);
          b_d    = abs_op(bus.in_b);
          sign_d = bus.in_a[OP_W-1] ^ bus.in_b[OP_W-1];
`else
          a_d    = bus.in_a;
          b_d    = bus.in_b;
`endif
          acc_d   = '0;
          step_d  = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (ZERO_SKIP && zero_op) begin
          acc_d   = '0;
          state_d = ST_DONE;
        end else begin
          acc_d  = acc_sum;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d = ST_DONE;
`ifdef MUL_SEQ_SIGNED_EN
            if (sign_q) acc_d = -acc_sum;
`endif
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef MUL_SEQ_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef MUL_SEQ_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.out_product = acc_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Scoreboard bench for mul8_seq_ctrl; expected products follow MUL_SEQ_SIGNED_EN.
module tb_mul8_seq_ctrl;
  import mul_seq_pkg::*;

`ifdef MUL_SEQ_SIGNED_EN
  localparam logic [15:0] EXP_FF_FF = 16'h0001;
  localparam logic [15:0] EXP_80_80 = 16'h4000;
  localparam logic [15:0] EXP_FF_05 = 16'hFFFB;
  localparam logic [15:0] EXP_7F_80 = 16'hC080;
  localparam logic [15:0] EXP_A5_3C = 16'hEAAC;
`else
  localparam logic [15:0] EXP_FF_FF = 16'hFE01;
  localparam logic [15:0] EXP_80_80 = 16'h4000;
  localparam logic [15:0] EXP_FF_05 = 16'h04FB;
  localparam logic [15:0] EXP_7F_80 = 16'h3F80;
  localparam logic [15:0] EXP_A5_3C = 16'h26AC;
`endif

  typedef struct {
    logic [15:0] prod;
    int          lat;
    int          acc_cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy, busy0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul8_seq_ctrl_if u_if ();
  mul8_seq_ctrl_if u_if0 ();

  mul8_seq_ctrl #(.ZERO_SKIP(1'b1)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (u_if),
    .busy (busy)
  );

  mul8_seq_ctrl #(.ZERO_SKIP(1'b0)) u_dut0 (
    .clk  (clk),
    .rst  (rst),
    .bus  (u_if0),
    .busy (busy0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on each result handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (u_if.out_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", {31'b0, u_if.out_valid}, 32'd0);
        end else begin
          if (!prev_valid)
            check({sb_q[0].name, "_latency"}, cyc - sb_q[0].acc_cyc, sb_q[0].lat);
          check({sb_q[0].name, "_product"}, {16'b0, u_if.out_product}, {16'b0, sb_q[0].prod});
          if (u_if.out_ready) void'(sb_q.pop_front());
        end
      end
      prev_valid = u_if.out_valid;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod,
                      input int lat, input string name, output int acc_cyc);
    @(posedge clk); #1;
    u_if.in_a     = a;
    u_if.in_b     = b;
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 50 && !u_if.in_ready; i++) begin
      @(posedge clk); #1;
    end
    acc_cyc = cyc + 1;
    if (!u_if.in_ready) begin
      check({name, "_accept"}, {31'b0, u_if.in_ready}, 32'd1);
    end else begin
      sb_q.push_back(exp_t'{prod: prod, lat: lat, acc_cyc: acc_cyc, name: name});
      @(posedge clk); #1;
    end
    u_if.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_drained"}, sb_q.size(), 32'd0);
    @(posedge clk); #1;
    check({name, "_in_ready_after"}, {31'b0, u_if.in_ready}, 32'd1);
    check({name, "_busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  // ZERO_SKIP=0 instance: a zero operand still takes the full four CALC steps.
  task automatic zero_noskip_test();
    int lat;
    @(posedge clk); #1;
    u_if0.in_a     = 8'h00;
    u_if0.in_b     = 8'h7B;
    u_if0.in_valid = 1'b1;
    check("noskip_in_ready", {31'b0, u_if0.in_ready}, 32'd1);
    @(posedge clk); #1;
    u_if0.in_valid = 1'b0;
    lat = 0;
    while (!u_if0.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("noskip_latency", lat, 32'd4);
    check("noskip_product", {16'b0, u_if0.out_product}, 32'h0);
    @(posedge clk); #1;
    check("noskip_released", {31'b0, u_if0.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0, acc1;
    rst            = 1'b1;
    u_if.in_a      = '0;
    u_if.in_b      = '0;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    u_if0.in_a     = '0;
    u_if0.in_b     = '0;
    u_if0.in_valid = 1'b0;
    u_if0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready",    {31'b0, u_if.in_ready},   32'd1);
    check("rst_out_valid",   {31'b0, u_if.out_valid},  32'd0);
    check("rst_out_product", {16'b0, u_if.out_product}, 32'd0);
    check("rst_busy",        {31'b0, busy},            32'd0);

    zero_noskip_test();

    send(8'h12, 8'h34, 16'h03A8, 4, "mul_12_34", acc0);
    wait_drain("mul_12_34");
    send(8'hFF, 8'hFF, EXP_FF_FF, 4, "mul_ff_ff", acc0);
    wait_drain("mul_ff_ff");
    send(8'h00, 8'h7B, 16'h0000, 1, "zskip_00_7b", acc0);
    wait_drain("zskip_00_7b");
    send(8'h7B, 8'h00, 16'h0000, 1, "zskip_7b_00", acc0);
    wait_drain("zskip_7b_00");

    send(8'h80, 8'h80, EXP_80_80, 4, "mul_80_80", acc0);
    send(8'hFF, 8'h05, EXP_FF_05, 4, "mul_ff_05", acc0);
    send(8'h7F, 8'h80, EXP_7F_80, 4, "mul_7f_80", acc0);
    wait_drain("edge_vectors");

    // Back-to-back with out_ready held high: one result every 6 cycles.
    send(8'h10, 8'h10, 16'h0100, 4, "mul_10_10", acc0);
    send(8'hA5, 8'h3C, EXP_A5_3C, 4, "mul_a5_3c", acc1);
    check("throughput_gap", acc1 - acc0, 32'd6);
    wait_drain("throughput");

    // Backpressure: result held while in_valid pulses with other operands.
    u_if.out_ready = 1'b0;
    send(8'h0F, 8'h10, 16'h00F0, 4, "bp_0f_10", acc0);
    for (int i = 0; i < 12; i++) begin
      u_if.in_a     = 8'hAA;
      u_if.in_b     = 8'h55;
      u_if.in_valid = (i % 2 == 0);
      check("bp_in_ready_low", {31'b0, u_if.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    wait_drain("bp_0f_10");

    // Reset two cycles into CALC aborts the pending result.
    send(8'h22, 8'h33, 16'h0000, 4, "abort", acc0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    check("abort_in_ready",    {31'b0, u_if.in_ready},   32'd1);
    check("abort_out_valid",   {31'b0, u_if.out_valid},  32'd0);
    check("abort_out_product", {16'b0, u_if.out_product}, 32'd0);
    check("abort_busy",        {31'b0, busy},            32'd0);
    send(8'h03, 8'h05, 16'h000F, 4, "mul_03_05", acc0);
    wait_drain("mul_03_05");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul8_seq_ctrl.md
# mul8_seq_ctrl

Multi-cycle controller that computes an 8x8 product by sequencing a single 4x4 array-multiplier datapath through four partial products and accumulating them. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Its purpose is to reuse the small combinational 4-bit multiplier instead of instantiating a full 8x8 array.

## Interface
- ZERO_SKIP, default 1: if 1, an operand pair with either operand equal to zero bypasses the CALC steps.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_a  input  8  multiplicand; sampled on acceptance.
- in_b  input  8  multiplier; sampled on acceptance.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  controller can accept an operand pair.
- out_product  output  16  result; stable while out_valid=1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- busy  output  1  high in any state other than IDLE.

## Operation
- Partial products (aL/aH and bL/bH are the low/high nibbles):
  - step0: aL*bL, shift 0.
  - step1: aH*bL, shift 4.
  - step2: aL*bH, shift 4.
  - step3: aH*bH, shift 8.
- Each step is added into a 16-bit accumulator. The unsigned 8x8 product never exceeds 0xFE01, so the sum never overflows.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. When in_valid & in_ready, latch the operands, clear the accumulator, set step=0 and go to CALC.
  - ZERO_SKIP=1 with a zero operand: go directly to DONE with the accumulator at 0.
  - CALC: each cycle, add the current step's partial product and increment step. After step3 is added, go to DONE.
  - DONE: out_valid=1 and out_product=accumulator. When out_ready=1, go to IDLE.
- in_ready is high only in IDLE. There is no operand acceptance in DONE, even when out_ready is high in the same cycle.
- in_valid while not in IDLE is ignored. The operand latches are not disturbed.
- out_ready outside DONE is ignored.
- Reset values:
  - state=IDLE, step=0, accumulator=0, operand latches=0.
  - out_product=0, out_valid=0, busy=0, in_ready=1 in the first cycle after reset.
- Reset mid-operation aborts the computation and discards any pending result.

## Timing
- Acceptance edge is T0.
- Accumulation occurs on edges T1..T4. out_valid is high after T4, i.e. 4 cycles after acceptance.
- ZERO_SKIP path: out_valid is high after T1.
- out_valid stays high until the edge on which out_ready=1 is sampled. After that edge, out_valid=0 and in_ready=1.
- Throughput with out_ready held high is one result per 6 cycles: accept, 4 CALC, DONE.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- MUL_SEQ_SIGNED_EN defined: in_a, in_b and out_product are two's complement.
  - On acceptance, the operand magnitudes are latched (-128 becomes 128) and sign = a[7]^b[7] is latched.
  - On the DONE transition, the accumulator is negated if sign=1.
  - Range: -128*-128 = 0x4000; -128*127 = 0xC080.
- Not defined: all values are unsigned, and there is no sign logic.
- Latency and handshakes are identical in both builds.

## Structure
- Package mul_seq_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the step index width (2);
  - the operand width (8), nibble width (4) and product width (16) constants.
- Sub-module pp_mul4 is the purely combinational 4x4 unsigned array multiplier: two 4-bit inputs, one 8-bit output. It is instantiated once. The controller muxes the nibbles into it by step.

## Test plan
- Unsigned 0x12 * 0x34, out_ready=1 → out_valid 4 cycles after acceptance, out_product=0x03A8; in_ready=1 on the following cycle.
- Unsigned 0xFF * 0xFF → out_product=0xFE01, with no overflow.
- 0x00 * 0x7B with ZERO_SKIP=1 → out_valid 1 cycle after acceptance, out_product=0x0000. With ZERO_SKIP=0 → result after 4 cycles, out_product=0x0000.
- Backpressure: 0x0F * 0x10 with out_ready=0 for 10 cycles → out_valid and out_product=0x00F0 held stable; in_valid pulses during this window are ignored; result is released on the first out_ready=1.
- Reset asserted 2 cycles into CALC → next cycle state=IDLE, out_valid=0, out_product=0, in_ready=1; a following 0x03 * 0x05 returns 0x000F.
- MUL_SEQ_SIGNED_EN builds:
  - 0x80 * 0x80 → 0x4000.
  - 0xFF * 0x05 → 0xFFFB.
  - 0x7F * 0x80 → 0xC080.
